ensemble_vote_collector: RTL and testbench
==========================================

// Module: ensemble_vote_collector
// PURPOSE
//  Sink side of the three-classifier ensemble. Consumes the three per-sample result streams
//  (Gaussian NB, logistic regression, MLP) and aligns them one sample at a time.
//  Majority-votes the predicted class and emits one AXI-Stream result beat per sample.
//  Sits directly downstream of the three classifier output ports.
// PARAMETERS
//  DATA_WIDTH   32  stream data width, all inputs and output
//  KEEP_WIDTH   4   tkeep width (DATA_WIDTH/8)
//  CLASS_WIDTH  4   class label width; label = tdata[CLASS_WIDTH-1:0] on each input
//  TIE_SEL      2   input index (0/1/2) whose label wins a three-way disagreement
// PORTS
//  clk              in   1           clock
//  rst              in   1           asynchronous reset, active-high
//  s_axis_tdata_k   in   DATA_WIDTH  classifier k result, k=0..2
//  s_axis_tkeep_k   in   KEEP_WIDTH  ignored
//  s_axis_tvalid_k  in   1           result k valid
//  s_axis_tready_k  out  1           collector can accept result k
//  s_axis_tlast_k   in   1           last sample of frame, from classifier k
//  m_axis_tdata     out  DATA_WIDTH  [CLASS_WIDTH-1:0]=voted class, [17:16]=vote count, [31:24]=sample idx, rest 0
//  m_axis_tkeep     out  KEEP_WIDTH  all ones while valid
//  m_axis_tvalid    out  1           result valid
//  m_axis_tready    in   1           downstream accepts
//  m_axis_tlast     out  1           copy of captured s_axis_tlast_0
//  tlast_err        out  1           sticky: captured tlast bits of a sample disagreed
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0, holding regs empty, idx=0, tlast_err=0.
//    s_axis_tready_k=0 while rst is high.
//  - Per input: one-entry holding reg {label,tlast}, flag full_k; captured on tvalid_k & tready_k.
//  - fire = full_0 & full_1 & full_2 & (~m_axis_tvalid | m_axis_tready).
//  - s_axis_tready_k = ~full_k | fire. Same-cycle clear and refill is allowed.
//  - fire loads the output register and clears every full_k not refilled that cycle.
//  - Latency: third input captured at edge E; m_axis_tvalid=1 after edge E+1.
//  - Throughput: sustained 1 sample/cycle when all inputs are valid and m_axis_tready=1.
//  - Skew: an early input holds its beat with tready low until the slowest input arrives.
//  - Output: tvalid/tdata/tlast held stable until m_axis_tready; no combinational path s->m.
//  - Vote, labels a,b,c from inputs 0,1,2:
//      a==b==c -> a, count 3
//      a==b or a==c -> a, count 2
//      b==c -> b, count 2
//      else -> label[TIE_SEL], count 1
//  - Sample idx (8b):
//      current value placed in tdata[31:24] on each fire, then incremented
//      wraps 255->0
//      reset to 0 after a fire whose output tlast=1 (next frame starts at idx 0)
//  - tlast_err set on fire if the three captured tlast bits are not all equal.
//    Cleared only by rst. Output tlast still follows input 0.
//  - Input tkeep and tdata bits above CLASS_WIDTH are ignored.
// CONFIGURATION
//  ENSEMBLE_VOTE_STATS_EN defined: adds ports stat_unan, stat_split, stat_tie (out, 16b each).
//    Saturating counters of fires with vote count 3/2/1. Reset to 0 by rst; hold at 16'hFFFF.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 labels 3,3,3 same cycle, tready=1 -> one beat, class 3, count 3, idx 0, tkeep=4'hF.
//  2 labels 1,5,5 -> class 5, count 2. Labels 0,1,2 with TIE_SEL=2 -> class 2, count 1.
//  3 inputs 0,1 at cycle 0, input 2 at cycle 10:
//      -> tready_0/1 low cycles 1-10
//      -> tvalid rises cycle 12
//      -> exactly one output beat
//  4 300 back-to-back samples, tready=1:
//      -> 1 beat/cycle after fill
//      -> idx wraps 255->0
//      -> tlast on sample 299 only; next sample starts at idx 0
//  5 m_axis_tready low 7 cycles mid-stream:
//      -> tdata stable while stalled
//      -> no loss or reordering
//      -> all s_axis_tready low once holding regs are full
//  6 tlast 1,0,1 on one sample -> tlast_err=1 stays high. Assert rst mid-stream -> all outputs 0 next cycle.
//    Stats build: 70000 unanimous samples -> stat_unan=16'hFFFF.

Source files
------------

// File: rtl/ensemble_vote_collector_if.sv
// AXI-Stream style result channel shared by the three classifier inputs and the voted output.
// Handshake: a beat transfers on a rising clk edge where tvalid & tready are both high; a master holds tdata/tlast stable while tvalid is high and tready is low.
interface ensemble_vote_collector_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ensemble_vote_collector.sv
// Aligns one result per classifier, majority-votes the class label and emits one registered beat per sample.
// Optional ENSEMBLE_VOTE_STATS_EN adds saturating counters of unanimous / split / tie votes.
module ensemble_vote_collector #(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int CLASS_WIDTH = 4,
  parameter int TIE_SEL     = 2
) (
  input  logic clk,
  input  logic rst,
  ensemble_vote_collector_if.slave  s_axis_0,
  ensemble_vote_collector_if.slave  s_axis_1,
  ensemble_vote_collector_if.slave  s_axis_2,
  ensemble_vote_collector_if.master m_axis,
  output logic tlast_err
`ifdef ENSEMBLE_VOTE_STATS_EN
  ,
  output logic [15:0] stat_unan,
  output logic [15:0] stat_split,
  output logic [15:0] stat_tie
`endif
);

  logic [2:0]             in_valid;
  logic [2:0]             in_last;
  logic [CLASS_WIDTH-1:0] in_label [3];
  logic [2:0]             full;
  logic [2:0]             last_q;
  logic [CLASS_WIDTH-1:0] label_q [3];
  logic [2:0]             ready;
  logic [2:0]             take;
  logic                   fire;

  logic                   out_valid;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_last;
  logic [7:0]             idx;

  logic [CLASS_WIDTH-1:0] vote_class;
  logic [1:0]             vote_count;
  logic [DATA_WIDTH-1:0]  vote_word;

  // Input tkeep and label-free tdata bits carry nothing for the vote.
  logic unused_inputs;
  assign unused_inputs = ^{s_axis_0.tkeep, s_axis_1.tkeep, s_axis_2.tkeep,
                           s_axis_0.tdata[DATA_WIDTH-1:CLASS_WIDTH],
                           s_axis_1.tdata[DATA_WIDTH-1:CLASS_WIDTH],
                           s_axis_2.tdata[DATA_WIDTH-1:CLASS_WIDTH]};

  assign in_valid    = {s_axis_2.tvalid, s_axis_1.tvalid, s_axis_0.tvalid};
  assign in_last     = {s_axis_2.tlast, s_axis_1.tlast, s_axis_0.tlast};
  assign in_label[0] = s_axis_0.tdata[CLASS_WIDTH-1:0];
  assign in_label[1] = s_axis_1.tdata[CLASS_WIDTH-1:0];
  assign in_label[2] = s_axis_2.tdata[CLASS_WIDTH-1:0];

  // Output register frees up either when empty or when its beat is taken this cycle.
  assign fire  = (&full) & (~out_valid | m_axis.tready);
  assign ready = rst ? 3'b000 : (~full | {3{fire}});
  assign take  = in_valid & ready;

  assign s_axis_0.tready = ready[0];
  assign s_axis_1.tready = ready[1];
  assign s_axis_2.tready = ready[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= '0;
      last_q  <= '0;
      label_q <= '{default: '0};
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (take[k]) begin
          full[k]    <= 1'b1;
          last_q[k]  <= in_last[k];
          label_q[k] <= in_label[k];
        end else if (fire) begin
          full[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    vote_class = label_q[TIE_SEL];
    vote_count = 2'd1;
    if (label_q[0] == label_q[1] && label_q[0] == label_q[2]) begin
      vote_class = label_q[0];
      vote_count = 2'd3;
    end else if (label_q[0] == label_q[1] || label_q[0] == label_q[2]) begin
      vote_class = label_q[0];
      vote_count = 2'd2;
    end else if (label_q[1] == label_q[2]) begin
      vote_class = label_q[1];
      vote_count = 2'd2;
    end
  end

  always_comb begin
    vote_word                  = '0;
    vote_word[CLASS_WIDTH-1:0] = vote_class;
    vote_word[17:16]           = vote_count;
    vote_word[31:24]           = idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      idx       <= '0;
      tlast_err <= 1'b0;
    end else begin
      if (fire) begin
        out_valid <= 1'b1;
        out_data  <= vote_word;
        out_last  <= last_q[0];
        idx       <= last_q[0] ? 8'd0 : idx + 8'd1;
        if (!(&last_q) && (|last_q)) tlast_err <= 1'b1;
      end else if (m_axis.tready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_data;
  assign m_axis.tlast  = out_last;
  assign m_axis.tkeep  = out_valid ? {KEEP_WIDTH{1'b1}} : {KEEP_WIDTH{1'b0}};

`ifdef ENSEMBLE_VOTE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_unan  <= '0;
      stat_split <= '0;
      stat_tie   <= '0;
    end else if (fire) begin
      if (vote_count == 2'd3 && stat_unan != 16'hFFFF) stat_unan <= stat_unan + 16'd1;
      if (vote_count == 2'd2 && stat_split != 16'hFFFF) stat_split <= stat_split + 16'd1;
      if (vote_count == 2'd1 && stat_tie != 16'hFFFF) stat_tie <= stat_tie + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ensemble_vote_collector.sv
// Bench for ensemble_vote_collector: vector table, skew/burst/stall/tlast/reset sequences, queue scoreboard.
// Build with ENSEMBLE_VOTE_STATS_EN defined to also cover the vote statistics counters.
module tb_ensemble_vote_collector;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int CW = 4;
  localparam int TIE = 2;
  localparam int TIMEOUT = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ensemble_vote_collector_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s0 ();
  ensemble_vote_collector_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s1 ();
  ensemble_vote_collector_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s2 ();
  ensemble_vote_collector_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) m ();
  logic tlast_err;
`ifdef ENSEMBLE_VOTE_STATS_EN
  logic [15:0] stat_unan, stat_split, stat_tie;
`endif

  ensemble_vote_collector #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CLASS_WIDTH(CW), .TIE_SEL(TIE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_0(s0.slave),
    .s_axis_1(s1.slave),
    .s_axis_2(s2.slave),
    .m_axis(m.master),
    .tlast_err(tlast_err)
`ifdef ENSEMBLE_VOTE_STATS_EN
    ,
    .stat_unan(stat_unan),
    .stat_split(stat_split),
    .stat_tie(stat_tie)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];
  int beat_cyc_q[$];
  logic [7:0] exp_idx = 8'd0;

  typedef struct {
    logic [CW-1:0] a, b, c;
    logic [CW-1:0] cls;
    logic [1:0]    cnt;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] make_word(logic [CW-1:0] cls, logic [1:0] cnt, logic [7:0] idx);
    logic [DW-1:0] w;
    w = '0;
    w[CW-1:0] = cls;
    w[17:16] = cnt;
    w[31:24] = idx;
    return w;
  endfunction

  task automatic push_exp(input logic [CW-1:0] cls, input logic [1:0] cnt, input logic last);
    exp_q.push_back({last, make_word(cls, cnt, exp_idx)});
    exp_idx = last ? 8'd0 : exp_idx + 8'd1;
  endtask

  // Reference vote: count how many inputs agree with a, then with b.
  task automatic push_model(input logic [CW-1:0] a, b, c, input logic last);
    int na, nb;
    na = 1 + int'(b == a) + int'(c == a);
    nb = 1 + int'(a == b) + int'(c == b);
    if (na >= 2) push_exp(a, 2'(na), last);
    else if (nb >= 2) push_exp(b, 2'(nb), last);
    else push_exp((TIE == 0) ? a : (TIE == 1) ? b : c, 2'd1, last);
  endtask

  // Offers one beat on every input; each channel drops tvalid once its own beat is taken.
  task automatic drive_sample(input logic [CW-1:0] a, b, c, input logic la, lb, lc);
    logic [2:0] pend, acc;
    int guard;
    s0.tdata = {$urandom()} & 32'hFFFF_FFF0 | {28'd0, a};
    s1.tdata = {$urandom()} & 32'hFFFF_FFF0 | {28'd0, b};
    s2.tdata = {$urandom()} & 32'hFFFF_FFF0 | {28'd0, c};
    s0.tkeep = 4'($urandom()); s1.tkeep = 4'($urandom()); s2.tkeep = 4'($urandom());
    s0.tlast = la; s1.tlast = lb; s2.tlast = lc;
    s0.tvalid = 1'b1; s1.tvalid = 1'b1; s2.tvalid = 1'b1;
    pend = 3'b111;
    guard = 0;
    while (pend != 3'b000) begin
      @(negedge clk);
      acc = pend & {s2.tready, s1.tready, s0.tready};
      @(posedge clk); #1;
      pend = pend & ~acc;
      if (acc[0]) s0.tvalid = 1'b0;
      if (acc[1]) s1.tvalid = 1'b0;
      if (acc[2]) s2.tvalid = 1'b0;
      guard++;
      if (guard > TIMEOUT && pend != 3'b000) begin
        checks++; errors++;
        $display("FAIL input_accept_timeout actual pending=%b required=000", pend);
        s0.tvalid = 1'b0; s1.tvalid = 1'b0; s2.tvalid = 1'b0;
        pend = 3'b000;
      end
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < TIMEOUT) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Scoreboard monitor: compares every accepted beat and the stability of stalled beats.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_last;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold", {m.tvalid, m.tlast, m.tdata}, {1'b1, held_last, held_data});
      end
      if (m.tvalid && m.tready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat actual data=%0h required=no beat", m.tdata);
        end else begin
          check("beat", {m.tlast, m.tdata}, exp_q.pop_front());
        end
        check("beat_tkeep", m.tkeep, 4'hF);
        beat_cyc_q.push_back(cyc);
      end
      prev_stall = m.tvalid && !m.tready;
      held_data  = m.tdata;
      held_last  = m.tlast;
    end
  end

  initial begin
    s0.tvalid = 0; s1.tvalid = 0; s2.tvalid = 0;
    s0.tdata = '0; s1.tdata = '0; s2.tdata = '0;
    s0.tkeep = '0; s1.tkeep = '0; s2.tkeep = '0;
    s0.tlast = 0; s1.tlast = 0; s2.tlast = 0;
    m.tready = 1'b1;
    rst = 1'b1;

    tbl[0] = '{a: 3, b: 3, c: 3, cls: 3, cnt: 3};
    tbl[1] = '{a: 1, b: 5, c: 5, cls: 5, cnt: 2};
    tbl[2] = '{a: 0, b: 1, c: 2, cls: 2, cnt: 1};
    tbl[3] = '{a: 7, b: 7, c: 2, cls: 7, cnt: 2};
    tbl[4] = '{a: 4, b: 9, c: 4, cls: 4, cnt: 2};
    tbl[5] = '{a: 15, b: 0, c: 15, cls: 15, cnt: 2};
    tbl[6] = '{a: 6, b: 8, c: 10, cls: 10, cnt: 1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tvalid", m.tvalid, 0);
    check("rst_tdata", m.tdata, 0);
    check("rst_tlast", m.tlast, 0);
    check("rst_tkeep", m.tkeep, 0);
    check("rst_tlast_err", tlast_err, 0);
    check("rst_s_tready", {s2.tready, s1.tready, s0.tready}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_tready", {s2.tready, s1.tready, s0.tready}, 3'b111);
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < 7; i++) begin
      push_exp(tbl[i].cls, tbl[i].cnt, 1'b0);
      drive_sample(tbl[i].a, tbl[i].b, tbl[i].c, 1'b0, 1'b0, 1'b0);
    end
    wait_drain();
    repeat (2) @(posedge clk); #1;

    // Skewed arrival: inputs 0/1 at cycle 0, input 2 at cycle 10
    beat_cyc_q.delete();
    push_model(4'd4, 4'd4, 4'd9, 1'b0);
    s0.tdata = 32'd4; s0.tlast = 0; s0.tvalid = 1;
    s1.tdata = 32'd4; s1.tlast = 0; s1.tvalid = 1;
    @(negedge clk);
    check("skew_ready_c0", {s1.tready, s0.tready}, 2'b11);
    @(posedge clk); #1;
    s0.tvalid = 0; s1.tvalid = 0;
    for (int n = 1; n <= 10; n++) begin
      if (n == 10) begin
        s2.tdata = 32'd9; s2.tlast = 0; s2.tvalid = 1;
      end
      @(negedge clk);
      check("skew_ready_low", {s1.tready, s0.tready}, 2'b00);
      check("skew_no_early_valid", m.tvalid, 0);
      @(posedge clk); #1;
    end
    s2.tvalid = 0;
    @(negedge clk);
    check("skew_valid_c11", m.tvalid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("skew_valid_c12", m.tvalid, 1);
    repeat (5) @(posedge clk); #1;
    check("skew_beat_count", 64'(beat_cyc_q.size()), 64'd1);
    wait_drain();

    // 300 back-to-back samples, tlast on the last one, idx wraps
    beat_cyc_q.delete();
    for (int i = 0; i < 300; i++) begin
      logic [CW-1:0] a, b, c;
      logic l;
      a = CW'($urandom_range(0, 3)); b = CW'($urandom_range(0, 3)); c = CW'($urandom_range(0, 3));
      l = (i == 299);
      push_model(a, b, c, l);
      drive_sample(a, b, c, l, l, l);
    end
    wait_drain();
    check("burst_beats", 64'(beat_cyc_q.size()), 64'd300);
    if (beat_cyc_q.size() == 300)
      check("burst_rate", 64'(beat_cyc_q[299] - beat_cyc_q[0]), 64'd299);
    push_model(4'd8, 4'd8, 4'd1, 1'b0);
    drive_sample(4'd8, 4'd8, 4'd1, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // Downstream stall of 7 cycles mid-stream
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic [CW-1:0] a, b, c;
          a = CW'($urandom_range(0, 15)); b = CW'($urandom_range(0, 15)); c = CW'($urandom_range(0, 15));
          push_model(a, b, c, 1'b0);
          drive_sample(a, b, c, 1'b0, 1'b0, 1'b0);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1 m.tready = 1'b0;
        for (int j = 0; j < 7; j++) begin
          @(negedge clk);
          if (j == 6) check("stall_s_tready", {s2.tready, s1.tready, s0.tready}, 3'b000);
        end
        @(posedge clk);
        #1 m.tready = 1'b1;
      end
    join
    wait_drain();

    // tlast disagreement
    check("tlast_err_clear", tlast_err, 0);
    push_model(4'd2, 4'd2, 4'd2, 1'b1);
    drive_sample(4'd2, 4'd2, 4'd2, 1'b1, 1'b0, 1'b1);
    wait_drain();
    check("tlast_err_set", tlast_err, 1);
    push_model(4'd5, 4'd5, 4'd5, 1'b0);
    drive_sample(4'd5, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0);
    wait_drain();
    check("tlast_err_sticky", tlast_err, 1);

    // Reset with data held in the output and holding registers
    m.tready = 1'b0;
    drive_sample(4'd1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
    drive_sample(4'd2, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    @(negedge clk);
    check("midrst_tvalid", m.tvalid, 0);
    check("midrst_tdata", m.tdata, 0);
    check("midrst_tlast", m.tlast, 0);
    check("midrst_tkeep", m.tkeep, 0);
    check("midrst_tlast_err", tlast_err, 0);
    check("midrst_s_tready", {s2.tready, s1.tready, s0.tready}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    m.tready = 1'b1;
    exp_idx = 8'd0;
    exp_q.delete();
    push_exp(tbl[1].cls, tbl[1].cnt, 1'b0);
    drive_sample(tbl[1].a, tbl[1].b, tbl[1].c, 1'b0, 1'b0, 1'b0);
    wait_drain();

`ifdef ENSEMBLE_VOTE_STATS_EN
    check("stat_split_small", stat_split, 1);
    for (int i = 0; i < 70000; i++) begin
      push_model(4'd7, 4'd7, 4'd7, 1'b0);
      drive_sample(4'd7, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0);
    end
    wait_drain();
    check("stat_unan_sat", stat_unan, 16'hFFFF);
    check("stat_tie_zero", stat_tie, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
